// File: rtl/pipe_stage_reg.sv
// Parametrised CPU pipeline-stage register with valid/ready back-pressure, flush with
// bubble insertion, an optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a beat moves on a rising edge only when valid && ready are both high on
  // that side; a producer holds valid and its payload steady until that happens.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              deliver;

  // With the skid buffer, readiness depends only on skid occupancy, cutting the
  // out_ready -> in_ready combinational path through the pipeline.
  always_comb begin
    if (SKID != 0) in_ready = ~clr & ~skid_valid;
    else           in_ready = ~clr & (~out_valid | out_ready);
  end

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      skid_valid <= 1'b0;
    end else if (deliver || !out_valid) begin
      // Main slot frees up: the skid entry is older than anything offered now.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_ctrl   <= skid_ctrl;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end else if (accept) begin
      // Only reachable with SKID=1: main is stalled, park the beat in the skid slot.
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
